// File: rtl/fir_folded_tdm.sv
// fir_folded_tdm: time-multiplexed symmetric FIR. N_TAPS/2 unique coefficients
// share one multiplier behind a pre-adder, one MAC per cycle, then a
// floor/saturate conversion to NB_OUTPUT bits.
// Build option: FIR_ROUND_EN selects round-half-up instead of floor before
// the LSB drop; latency is the same in both builds.
module fir_folded_tdm #(
    parameter int NB_INPUT  = 16,
    parameter int NB_COEF   = 16,
    parameter int NB_OUTPUT = 18,
    parameter int N_TAPS    = 8,
    localparam int H        = N_TAPS / 2,
    localparam int AW       = (H > 1) ? $clog2(H) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NB_INPUT-1:0]  i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_coef_we,
    input  logic [AW-1:0]        i_coef_addr,
    input  logic [NB_COEF-1:0]   i_coef_data,
    output logic [NB_OUTPUT-1:0] o_data,
    output logic                 o_valid
);
    localparam int IW  = $clog2(N_TAPS);
    localparam int GB  = $clog2(H);
    localparam int PW  = NB_INPUT + 1;
    localparam int MW  = NB_INPUT + NB_COEF + 1;
`ifdef FIR_ROUND_EN
    localparam int RB  = 1;
`else
    localparam int RB  = 0;
`endif
    localparam int ACW = MW + GB + RB;
    localparam int SW  = ACW - (NB_COEF - 1);
    localparam int WW  = ((SW > NB_OUTPUT) ? SW : NB_OUTPUT) + 1;

    localparam logic signed [WW-1:0] OMAX = {{(WW-NB_OUTPUT+1){1'b0}}, {(NB_OUTPUT-1){1'b1}}};
    localparam logic signed [WW-1:0] OMIN = {{(WW-NB_OUTPUT+1){1'b1}}, {(NB_OUTPUT-1){1'b0}}};
    localparam logic [NB_OUTPUT-1:0] SAT_MAX = {1'b0, {(NB_OUTPUT-1){1'b1}}};
    localparam logic [NB_OUTPUT-1:0] SAT_MIN = {1'b1, {(NB_OUTPUT-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                     state;
    logic signed [NB_INPUT-1:0] x      [N_TAPS];
    logic signed [NB_COEF-1:0]  shadow [H];
    logic signed [NB_COEF-1:0]  active [H];
    logic [AW-1:0]              k;
    logic signed [ACW-1:0]      acc;

    logic [IW-1:0]              idx_lo, idx_hi;
    logic signed [PW-1:0]       pre;
    logic signed [MW-1:0]       prod;
    logic signed [ACW-1:0]      acc_nxt;
    logic signed [ACW-1:0]      acc_r;
    logic signed [WW-1:0]       sh_w;
    logic [NB_OUTPUT-1:0]       sat;

    // Idle means ready, but never while reset is being held.
    assign o_ready = (state == S_IDLE) && !i_rst;

    // One folded tap pair per cycle: pre-add the mirrored samples, multiply, accumulate.
    always_comb begin
        idx_lo  = IW'(k);
        idx_hi  = IW'(N_TAPS - 1) - IW'(k);
        pre     = PW'(x[idx_lo]) + PW'(x[idx_hi]);
        prod    = MW'(pre) * MW'(active[k]);
        acc_nxt = acc + ACW'(prod);
    end

    // Drop the coefficient fraction bits (optionally rounding first), then clamp.
    always_comb begin
`ifdef FIR_ROUND_EN
        acc_r = acc + (ACW'(1) <<< (NB_COEF - 2));
`else
        acc_r = acc;
`endif
        sh_w = {{(WW-SW){acc_r[ACW-1]}}, acc_r[ACW-1:NB_COEF-1]};
        if (sh_w > OMAX)      sat = SAT_MAX;
        else if (sh_w < OMIN) sat = SAT_MIN;
        else                  sat = sh_w[NB_OUTPUT-1:0];
    end

    // Shadow bank takes writes at any time; out-of-range addresses are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < H; i++) shadow[i] <= '0;
        end else if (i_coef_we && int'(i_coef_addr) < H) begin
            shadow[i_coef_addr] <= i_coef_data;
        end
    end

    // Control FSM plus datapath registers: accept -> H MAC cycles -> output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            k       <= '0;
            acc     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) x[i] <= '0;
            for (int i = 0; i < H; i++) active[i] <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        x[0] <= i_data;
                        for (int i = 1; i < N_TAPS; i++) x[i] <= x[i-1];
                        // A write landing on the accept edge must reach the active bank too.
                        for (int i = 0; i < H; i++)
                            active[i] <= (i_coef_we && int'(i_coef_addr) == i) ? i_coef_data : shadow[i];
                        acc   <= '0;
                        k     <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc_nxt;
                    if (k == AW'(H - 1)) state <= S_OUT;
                    else                 k     <= k + 1'b1;
                end
                S_OUT: begin
                    o_data  <= sat;
                    o_valid <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
